// File: rtl/pipe_ctrl_if.sv
// Handshake/control bundle between the pipeline sequencer and fetch/decode.
// The master side owns the decode/execute status. The slave side is pipe_ctrl.
interface pipe_ctrl_if;
   logic        start;
   logic [3:0]  dec_op;
   logic [3:0]  dec_rd;
   logic [3:0]  dec_rs;
   logic        exe_is_mem_read;
   logic [3:0]  exe_rd;
   logic        do_branch;
   logic        do_jump;
   logic        pc_stall;
   logic        dec_stall;
   logic        dec_flush;
   logic        fetch_flush;
   logic [1:0]  pc_sel;
   logic        running;
   logic        halted;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   modport master (
      output start, dec_op, dec_rd, dec_rs, exe_is_mem_read, exe_rd, do_branch, do_jump,
      input  pc_stall, dec_stall, dec_flush, fetch_flush, pc_sel, running, halted,
             stall_cnt, flush_cnt
   );

   modport slave (
      input  start, dec_op, dec_rd, dec_rs, exe_is_mem_read, exe_rd, do_branch, do_jump,
      output pc_stall, dec_stall, dec_flush, fetch_flush, pc_sel, running, halted,
             stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: start-up, load-use interlock, branch/jump flush, halt drain.
// Controls are Mealy (state + current inputs); state and counters are registered.
module pipe_ctrl #(
   parameter int BRANCH_PENALTY = 2,
   parameter int DRAIN_CYCLES   = 3
) (
   input logic        clk,
   input logic        rst,
   pipe_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_FLUSH,
      S_DRAIN,
      S_HALTED
   } state_t;

   localparam logic [2:0] FLUSH_LD = 3'(BRANCH_PENALTY - 1);
   localparam logic [2:0] DRAIN_LD = 3'(DRAIN_CYCLES);
   localparam logic [15:0] SAT     = 16'hFFFF;

   state_t      state;
   logic [2:0]  cnt;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   logic uses_rd, uses_rs, load_use, halt_dec;
   logic active;

   always_comb begin
      uses_rd = 1'b0;
      case (bus.dec_op)
         4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10, 4'd12, 4'd13: uses_rd = 1'b1;
         default: uses_rd = 1'b0;
      endcase
   end

   always_comb begin
      uses_rs = 1'b0;
      case (bus.dec_op)
         4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10, 4'd12, 4'd13: uses_rs = 1'b1;
         default: uses_rs = 1'b0;
      endcase
   end

   assign load_use = bus.exe_is_mem_read &&
                     ((uses_rd && (bus.dec_rd == bus.exe_rd)) ||
                      (uses_rs && (bus.dec_rs == bus.exe_rd)));
   assign halt_dec = (bus.dec_op == 4'b1111);
   assign active   = (state == S_RUN) || (state == S_FLUSH) || (state == S_DRAIN);

   // Mealy control decode; do_branch preempts everything in the active states.
   always_comb begin
      bus.pc_stall    = 1'b0;
      bus.dec_stall   = 1'b0;
      bus.dec_flush   = 1'b0;
      bus.fetch_flush = 1'b0;
      bus.pc_sel      = 2'd0;
      case (state)
         S_RUN: begin
            if (bus.do_branch) begin
               bus.pc_sel      = 2'd2;
               bus.fetch_flush = 1'b1;
               bus.dec_flush   = 1'b1;
            end else if (bus.do_jump) begin
               bus.pc_sel      = 2'd1;
               bus.fetch_flush = 1'b1;
            end else if (load_use) begin
               bus.pc_stall    = 1'b1;
               bus.dec_stall   = 1'b1;
               bus.dec_flush   = 1'b1;
            end else if (halt_dec) begin
               bus.pc_stall    = 1'b1;
               bus.fetch_flush = 1'b1;
            end
         end
         S_FLUSH: begin
            bus.fetch_flush = 1'b1;
            bus.dec_flush   = 1'b1;
            if (bus.do_branch) bus.pc_sel = 2'd2;
         end
         S_DRAIN: begin
            if (bus.do_branch) begin
               bus.pc_sel      = 2'd2;
               bus.fetch_flush = 1'b1;
               bus.dec_flush   = 1'b1;
            end else begin
               bus.pc_stall    = 1'b1;
               bus.dec_stall   = 1'b1;
               bus.dec_flush   = 1'b1;
            end
         end
         default: begin
            bus.pc_stall  = 1'b1;
            bus.dec_stall = 1'b1;
            bus.dec_flush = 1'b1;
         end
      endcase
   end

   assign bus.running   = active;
   assign bus.halted    = (state == S_HALTED);
   assign bus.stall_cnt = stall_cnt;
   assign bus.flush_cnt = flush_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         cnt       <= 3'd0;
         stall_cnt <= 16'd0;
         flush_cnt <= 16'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) state <= S_RUN;
            end
            S_RUN, S_FLUSH, S_DRAIN: begin
               if (bus.do_branch) begin
                  if (flush_cnt != SAT) flush_cnt <= flush_cnt + 16'd1;
                  if (BRANCH_PENALTY > 1) begin
                     state <= S_FLUSH;
                     cnt   <= FLUSH_LD;
                  end else begin
                     state <= S_RUN;
                  end
               end else if (state == S_RUN) begin
                  if (bus.do_jump) begin
                     if (flush_cnt != SAT) flush_cnt <= flush_cnt + 16'd1;
                  end else if (load_use) begin
                     if (stall_cnt != SAT) stall_cnt <= stall_cnt + 16'd1;
                  end else if (halt_dec) begin
                     state <= S_DRAIN;
                     cnt   <= DRAIN_LD;
                  end
               end else begin
                  // cnt == 1 marks the last FLUSH/DRAIN cycle
                  cnt <= cnt - 3'd1;
                  if (cnt <= 3'd1) state <= (state == S_FLUSH) ? S_RUN : S_HALTED;
               end
            end
            default: state <= S_HALTED;
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized bench for pipe_ctrl against a cycle-level reference model built
// from remaining-cycle counts and modes rather than the RTL encoding.
module tb_pipe_ctrl;
   localparam int BP = 2;
   localparam int DC = 3;
   localparam int M_IDLE = 0, M_RUN = 1, M_FLUSH = 2, M_DRAIN = 3, M_HALT = 4;

   logic clk;
   logic rst;
   pipe_ctrl_if bus ();

   pipe_ctrl #(.BRANCH_PENALTY(BP), .DRAIN_CYCLES(DC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   int mode;
   int left;
   int m_stall;
   int m_flush;

   logic e_ps, e_ds, e_df, e_ff, e_run, e_halt;
   logic [1:0] e_sel;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic lu_now();
      logic rd_u, rs_u;
      rd_u = bus.dec_op inside {[4'd1:4'd7], 4'd10, 4'd12, 4'd13};
      rs_u = bus.dec_op inside {[4'd1:4'd4], 4'd9, 4'd10, 4'd12, 4'd13};
      return bus.exe_is_mem_read &&
             ((rd_u && bus.dec_rd == bus.exe_rd) || (rs_u && bus.dec_rs == bus.exe_rd));
   endfunction

   task automatic model_out();
      {e_ps, e_ds, e_df, e_ff, e_sel} = '0;
      e_run  = (mode == M_RUN || mode == M_FLUSH || mode == M_DRAIN);
      e_halt = (mode == M_HALT);
      case (mode)
         M_RUN: begin
            if (bus.do_branch)           begin e_sel = 2; e_ff = 1; e_df = 1; end
            else if (bus.do_jump)        begin e_sel = 1; e_ff = 1; end
            else if (lu_now())           begin e_ps = 1; e_ds = 1; e_df = 1; end
            else if (bus.dec_op == 4'hF) begin e_ps = 1; e_ff = 1; end
         end
         M_FLUSH: begin
            e_ff = 1; e_df = 1;
            if (bus.do_branch) e_sel = 2;
         end
         M_DRAIN: begin
            if (bus.do_branch) begin e_sel = 2; e_ff = 1; e_df = 1; end
            else               begin e_ps = 1; e_ds = 1; e_df = 1; end
         end
         default: begin e_ps = 1; e_ds = 1; e_df = 1; end
      endcase
   endtask

   task automatic model_clock();
      if (mode == M_IDLE) begin
         if (bus.start) mode = M_RUN;
      end else if (mode != M_HALT) begin
         if (bus.do_branch) begin
            if (m_flush < 65535) m_flush++;
            left = BP - 1;
            mode = (left > 0) ? M_FLUSH : M_RUN;
         end else if (mode == M_RUN) begin
            if (bus.do_jump) begin
               if (m_flush < 65535) m_flush++;
            end else if (lu_now()) begin
               if (m_stall < 65535) m_stall++;
            end else if (bus.dec_op == 4'hF) begin
               mode = M_DRAIN;
               left = DC;
            end
         end else begin
            left--;
            if (left == 0) mode = (mode == M_FLUSH) ? M_RUN : M_HALT;
         end
      end
   endtask

   task automatic check_all(input string tag);
      model_out();
      chk({tag, ":pc_stall"},    16'(bus.pc_stall),    16'(e_ps));
      chk({tag, ":dec_stall"},   16'(bus.dec_stall),   16'(e_ds));
      chk({tag, ":dec_flush"},   16'(bus.dec_flush),   16'(e_df));
      chk({tag, ":fetch_flush"}, 16'(bus.fetch_flush), 16'(e_ff));
      chk({tag, ":pc_sel"},      16'(bus.pc_sel),      16'(e_sel));
      chk({tag, ":running"},     16'(bus.running),     16'(e_run));
      chk({tag, ":halted"},      16'(bus.halted),      16'(e_halt));
      chk({tag, ":stall_cnt"},   bus.stall_cnt,        16'(m_stall));
      chk({tag, ":flush_cnt"},   bus.flush_cnt,        16'(m_flush));
   endtask

   // inputs are driven by the caller; check mid-cycle, then clock the model
   task automatic step(input string tag);
      #1;
      check_all(tag);
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic idle_in();
      bus.start = 0; bus.dec_op = 0; bus.dec_rd = 0; bus.dec_rs = 0;
      bus.exe_is_mem_read = 0; bus.exe_rd = 0; bus.do_branch = 0; bus.do_jump = 0;
   endtask

   // asynchronous reset pulse between clock edges
   task automatic pulse_reset(input string tag);
      rst = 1'b0;
      #1;
      chk({tag, ":rst_pc_stall"},  16'(bus.pc_stall),    16'd1);
      chk({tag, ":rst_dec_stall"}, 16'(bus.dec_stall),   16'd1);
      chk({tag, ":rst_dec_flush"}, 16'(bus.dec_flush),   16'd1);
      chk({tag, ":rst_fflush"},    16'(bus.fetch_flush), 16'd0);
      chk({tag, ":rst_pc_sel"},    16'(bus.pc_sel),      16'd0);
      chk({tag, ":rst_running"},   16'(bus.running),     16'd0);
      chk({tag, ":rst_halted"},    16'(bus.halted),      16'd0);
      chk({tag, ":rst_stall_cnt"}, bus.stall_cnt,        16'd0);
      chk({tag, ":rst_flush_cnt"}, bus.flush_cnt,        16'd0);
      mode = M_IDLE; left = 0; m_stall = 0; m_flush = 0;
      rst = 1'b1;
      #1;
   endtask

   task automatic rand_in();
      bus.start           = ($urandom_range(3) == 0);
      bus.dec_op          = 4'($urandom_range(15));
      bus.dec_rd          = 4'($urandom_range(3));
      bus.dec_rs          = 4'($urandom_range(3));
      bus.exe_is_mem_read = 1'($urandom_range(1));
      bus.exe_rd          = 4'($urandom_range(3));
      bus.do_branch       = ($urandom_range(5) == 0);
      bus.do_jump         = ($urandom_range(5) == 0);
   endtask

   initial begin
      mode = M_IDLE; left = 0; m_stall = 0; m_flush = 0;
      idle_in();
      rst = 1'b0;
      #2;
      check_all("reset");
      @(negedge clk);
      rst = 1'b1;
      #1;

      // start-up
      bus.start = 1; step("idle_start");
      bus.start = 0; step("run_first");
      chk("running_after_start", 16'(bus.running), 16'd1);

      // load-use, then ldi that must not stall
      bus.exe_is_mem_read = 1; bus.exe_rd = 3; bus.dec_op = 1; bus.dec_rs = 3; step("lu");
      bus.exe_is_mem_read = 0; step("lu_clear");
      chk("stall_cnt_one", bus.stall_cnt, 16'd1);
      bus.exe_is_mem_read = 1; bus.dec_op = 8; step("ldi_nostall");
      bus.exe_is_mem_read = 0; bus.dec_op = 0;

      // taken branch, penalty 2
      bus.do_branch = 1; step("br");
      bus.do_branch = 0; step("br_flush");
      step("br_back");
      chk("flush_cnt_one", bus.flush_cnt, 16'd1);

      // branch + load-use together
      bus.do_branch = 1; bus.exe_is_mem_read = 1; bus.dec_op = 1; step("br_lu");
      bus.do_branch = 0; bus.exe_is_mem_read = 0; bus.dec_op = 0; step("br_lu_flush");
      chk("br_lu_stall_cnt", bus.stall_cnt, 16'd1);

      // halt drains to HALTED
      bus.dec_op = 15; step("halt_dec");
      bus.dec_op = 0;
      for (int i = 0; i < DC; i++) step("drain");
      chk("halted_up", 16'(bus.halted), 16'd1);
      step("halted_hold");

      // halt abandoned by an older branch
      pulse_reset("rst_a");
      bus.start = 1; step("start2");
      bus.start = 0;
      bus.dec_op = 15; step("halt2");
      bus.dec_op = 0; step("drain2");
      bus.do_branch = 1; step("drain_br");
      bus.do_branch = 0;
      for (int i = 0; i < 5; i++) step("after_drain_br");
      chk("never_halted", 16'(bus.halted), 16'd0);

      // reset mid-FLUSH
      bus.do_branch = 1; step("br_pre_rst");
      bus.do_branch = 0;
      pulse_reset("mid_flush");

      // randomized run with occasional async resets
      for (int i = 0; i < 1500; i++) begin
         rand_in();
         if ($urandom_range(29) == 0) pulse_reset("rand_rst");
         step("rand");
      end

      // stall counter saturation
      idle_in();
      pulse_reset("rst_sat");
      bus.start = 1; step("start_sat");
      bus.start = 0;
      bus.exe_is_mem_read = 1; bus.exe_rd = 3; bus.dec_op = 1; bus.dec_rs = 3;
      for (int i = 0; i < 65537; i++) step("sat");
      chk("stall_sat", bus.stall_cnt, 16'hFFFF);
      idle_in();
      step("sat_end");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
